// File: rtl/jtframe_z80_romslot_if.sv
// Bus bundle between the CPU decoder / SDRAM slot (master) and the ROM slot (slave).
interface jtframe_z80_romslot_if #(
  parameter int unsigned AW = 16
);
  logic          cs;
  logic [AW-1:0] addr;
  logic          flush;
  logic [7:0]    dout;
  logic          rom_cs;
  logic          rom_ok;
  logic [AW-2:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ok;
  logic [15:0]   sdram_data;

  modport master (
    output cs, addr, flush, sdram_ok, sdram_data,
    input  dout, rom_cs, rom_ok, sdram_addr, sdram_req
  );

  modport slave (
    input  cs, addr, flush, sdram_ok, sdram_data,
    output dout, rom_cs, rom_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtframe_z80_romslot.sv
// Z80 ROM slot: 2-entry word cache in front of one SDRAM read slot.
// Hits are answered combinationally; misses issue one held word request.
module jtframe_z80_romslot #(
  parameter int unsigned AW = 16,
  parameter bit          LE = 1'b1
) (
  input  logic                  rst_n,
  input  logic                  clk,
  jtframe_z80_romslot_if.slave  bus
);
  localparam int unsigned WW = AW - 1;

  typedef enum logic {StIdle, StWait} state_t;

  state_t             r_state, w_state_d;
  logic               r_req, w_req_d;
  logic [WW-1:0]      r_saddr, w_saddr_d;
  logic               r_stale, w_stale_d;
  logic               w_fill;

  logic [1:0]         r_valid;
  logic [1:0][WW-1:0] r_tag;
  logic [1:0][15:0]   r_data;
  logic               r_lru;

  logic [1:0]         w_hit;
  logic               w_any_hit;
  logic [15:0]        w_word;
  logic               w_hi;

  // Tag compare against both entries, byte select from the hitting word.
  always_comb begin
    w_hit[0]  = r_valid[0] && (r_tag[0] == bus.addr[AW-1:1]);
    w_hit[1]  = r_valid[1] && (r_tag[1] == bus.addr[AW-1:1]);
    w_any_hit = |w_hit;
    w_word    = w_hit[1] ? r_data[1] : r_data[0];
    w_hi      = LE ? bus.addr[0] : ~bus.addr[0];
  end

  assign bus.rom_cs     = bus.cs;
  assign bus.rom_ok     = bus.cs && w_any_hit && !bus.flush;
  assign bus.dout       = w_hi ? w_word[15:8] : w_word[7:0];
  assign bus.sdram_addr = r_saddr;
  assign bus.sdram_req  = r_req;

  // Next-state logic: launch a request on a miss, finish it on sdram_ok.
  always_comb begin
    w_state_d = r_state;
    w_req_d   = r_req;
    w_saddr_d = r_saddr;
    w_stale_d = r_stale;
    w_fill    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.cs && !w_any_hit && !bus.flush) begin
          w_saddr_d = bus.addr[AW-1:1];
          w_req_d   = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        // A flush while waiting poisons the word already in flight.
        if (bus.flush) w_stale_d = 1'b1;
        if (bus.sdram_ok) begin
          w_fill    = !r_stale && !bus.flush;
          w_req_d   = 1'b0;
          w_stale_d = 1'b0;
          w_state_d = StIdle;
        end
      end
    endcase
  end

  // Request FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_req   <= 1'b0;
      r_saddr <= '0;
      r_stale <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_req   <= w_req_d;
      r_saddr <= w_saddr_d;
      r_stale <= w_stale_d;
    end
  end

  // Cache contents and victim pointer: flush beats fill, fill beats hit update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_lru   <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= '0;
      if (r_state == StIdle) r_lru <= 1'b0;
    end else if (w_fill) begin
      r_valid[r_lru] <= 1'b1;
      r_tag[r_lru]   <= r_saddr;
      r_data[r_lru]  <= bus.sdram_data;
      r_lru          <= ~r_lru;
    end else if (bus.cs && w_hit[0]) begin
      r_lru <= 1'b1;
    end else if (bus.cs && w_hit[1]) begin
      r_lru <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jtframe_z80_romslot.sv
// Self-checking bench for jtframe_z80_romslot: directed scenarios then random traffic,
// compared every cycle against a behavioural cache model.
module tb_jtframe_z80_romslot;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtframe_z80_romslot_if #(.AW(16)) bus ();

  jtframe_z80_romslot #(.AW(16), .LE(1'b1)) dut (
    .rst_n (rst_n),
    .clk   (clk),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: two cache slots, a victim index and one outstanding fetch.
  bit          m_valid [2];
  logic [14:0] m_tag   [2];
  logic [15:0] m_data  [2];
  int          m_victim;
  bit          m_busy;
  bit          m_stale;
  logic [14:0] m_paddr;

  // SDRAM responder control.
  bit auto_resp;
  bit rand_lat;
  int lat;
  int wait_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem(logic [14:0] w);
    logic [31:0] p;
    if (w == 15'h0091) return 16'hBEEF;
    p = {17'd0, w} * 32'd40503;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  function automatic int lookup(logic [15:0] a);
    for (int i = 0; i < 2; i++)
      if (m_valid[i] && m_tag[i] == a[15:1]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] exp_byte(int h, logic [15:0] a);
    logic [15:0] w;
    w = m_data[(h >= 0) ? h : 0];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_victim = 0;
    m_busy   = 1'b0;
    m_stale  = 1'b0;
    m_paddr  = '0;
    wait_cnt = 0;
    bus.sdram_ok = 1'b0;
  endtask

  task automatic model_update(int h);
    bit acc;
    if (!m_busy) begin
      if (bus.flush) begin
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_victim   = 0;
      end else if (bus.cs && h >= 0) begin
        m_victim = 1 - h;
      end else if (bus.cs) begin
        m_busy  = 1'b1;
        m_paddr = bus.addr[15:1];
      end
    end else begin
      acc = bus.sdram_ok && !m_stale && !bus.flush;
      if (bus.flush) begin
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
      end
      if (acc) begin
        m_valid[m_victim] = 1'b1;
        m_tag[m_victim]   = m_paddr;
        m_data[m_victim]  = bus.sdram_data;
        m_victim          = 1 - m_victim;
      end else if (bus.cs && h >= 0 && !bus.flush) begin
        m_victim = 1 - h;
      end
      if (bus.sdram_ok) begin
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (bus.flush) begin
        m_stale = 1'b1;
      end
    end
  endtask

  // Drives sdram_ok/sdram_data for the coming cycle from the model's view of the fetch.
  task automatic respond();
    if (!auto_resp) return;
    if (m_busy) begin
      if (wait_cnt == 0 && rand_lat) lat = int'($urandom_range(5, 1));
      wait_cnt++;
      bus.sdram_ok   = (wait_cnt >= lat);
      bus.sdram_data = mem(m_paddr);
    end else begin
      wait_cnt       = 0;
      bus.sdram_ok   = rand_lat && ($urandom_range(15, 0) == 0);
      bus.sdram_data = 16'($urandom);
    end
  endtask

  // One clock: check outputs at negedge, advance model at posedge, then set up responder.
  task automatic cycle();
    int h;
    @(negedge clk);
    h = lookup(bus.addr);
    chk("rom_cs", 32'(bus.rom_cs), 32'(bus.cs));
    chk("rom_ok", 32'(bus.rom_ok), 32'(bus.cs && h >= 0 && !bus.flush));
    chk("dout", 32'(bus.dout), 32'(exp_byte(h, bus.addr)));
    chk("sdram_req", 32'(bus.sdram_req), 32'(m_busy));
    if (m_busy) chk("sdram_addr", 32'(bus.sdram_addr), 32'(m_paddr));
    @(posedge clk);
    model_update(h);
    #1;
    respond();
  endtask

  task automatic fetch(logic [15:0] a);
    bit done;
    done    = 1'b0;
    bus.cs   = 1'b1;
    bus.addr = a;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = !m_busy && lookup(a) >= 0;
    end
    chk("fetch_done", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cs = 1'b0;
    bus.addr = '0;
    bus.flush = 1'b0;
    bus.sdram_ok = 1'b0;
    bus.sdram_data = '0;
    auto_resp = 1'b1;
    rand_lat = 1'b0;
    lat = 4;
    model_reset();

    // Reset state: nothing valid, even with cs on the all-zero tag.
    repeat (2) @(negedge clk);
    bus.cs = 1'b1;
    #1;
    chk("rst_rom_ok", 32'(bus.rom_ok), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_req", 32'(bus.sdram_req), 32'd0);
    chk("rst_saddr", 32'(bus.sdram_addr), 32'd0);
    bus.cs = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    respond();

    // Miss on 0x0123: request word 0x0091, byte 0xBE after the fill.
    bus.cs = 1'b1;
    bus.addr = 16'h0123;
    cycle();
    chk("t1_req", 32'(bus.sdram_req), 32'd1);
    chk("t1_saddr", 32'(bus.sdram_addr), 32'h0091);
    fetch(16'h0123);
    chk("t1_rom_ok", 32'(bus.rom_ok), 32'd1);
    chk("t1_dout", 32'(bus.dout), 32'h00BE);

    // Other byte of the same word hits immediately.
    bus.addr = 16'h0122;
    #1;
    chk("t2_rom_ok", 32'(bus.rom_ok), 32'd1);
    chk("t2_dout", 32'(bus.dout), 32'h00EF);
    cycle();
    chk("t2_no_req", 32'(bus.sdram_req), 32'd0);

    // LRU replacement: 0x0200 is the victim after touching 0x0100.
    bus.cs = 1'b0;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    fetch(16'h0100);
    fetch(16'h0200);
    fetch(16'h0100);
    fetch(16'h0300);
    bus.addr = 16'h0100;
    #1;
    chk("t3_keep_0100", 32'(bus.rom_ok), 32'd1);
    bus.addr = 16'h0200;
    #1;
    chk("t3_evict_0200", 32'(bus.rom_ok), 32'd0);
    bus.cs = 1'b0;

    // cs drops mid-wait: request is held and the fill still lands.
    lat = 6;
    bus.cs = 1'b1;
    bus.addr = 16'h4000;
    cycle();
    bus.cs = 1'b0;
    cycle();
    cycle();
    chk("t4_req_held", 32'(bus.sdram_req), 32'd1);
    for (int i = 0; i < 20 && m_busy; i++) cycle();
    chk("t4_req_drop", 32'(bus.sdram_req), 32'd0);
    bus.cs = 1'b1;
    #1;
    chk("t4_hit", 32'(bus.rom_ok), 32'd1);
    cycle();
    chk("t4_no_req", 32'(bus.sdram_req), 32'd0);

    // Flush during wait: first word discarded, second request for 0x2800.
    lat = 4;
    bus.addr = 16'h5000;
    cycle();
    cycle();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    for (int i = 0; i < 20 && m_busy; i++) cycle();
    chk("t5_discard", 32'(bus.rom_ok), 32'd0);
    cycle();
    chk("t5_rereq", 32'(bus.sdram_req), 32'd1);
    chk("t5_saddr", 32'(bus.sdram_addr), 32'h2800);
    fetch(16'h5000);
    chk("t5_rom_ok", 32'(bus.rom_ok), 32'd1);

    // Spurious sdram_ok while idle changes nothing.
    auto_resp = 1'b0;
    bus.cs = 1'b0;
    bus.sdram_ok = 1'b1;
    bus.sdram_data = 16'h1234;
    cycle();
    bus.sdram_ok = 1'b0;
    chk("spur_req", 32'(bus.sdram_req), 32'd0);
    auto_resp = 1'b1;
    respond();

    // Asynchronous reset mid-wait.
    fetch(16'h0600);
    bus.addr = 16'h0700;
    cycle();
    bus.addr = 16'h0600;
    #1;
    chk("t6_pre_hit", 32'(bus.rom_ok), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rom_ok", 32'(bus.rom_ok), 32'd0);
    chk("t6_req", 32'(bus.sdram_req), 32'd0);
    chk("t6_dout", 32'(bus.dout), 32'd0);
    model_reset();
    bus.cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    respond();
    bus.cs = 1'b1;
    cycle();
    chk("t6_miss", 32'(bus.sdram_req), 32'd1);
    fetch(16'h0600);

    // Random traffic against the model.
    rand_lat = 1'b1;
    repeat (800) begin
      int r;
      r = int'($urandom_range(9, 0));
      bus.cs = ($urandom_range(3, 0) != 0);
      if (r < 6)       bus.addr = 16'h0100 + 16'($urandom_range(7, 0));
      else if (r < 8)  bus.addr = 16'h0300 | 16'($urandom_range(1, 0));
      else if (r == 8) bus.addr = 16'h4000 | 16'($urandom_range(1, 0));
      else             bus.addr = 16'($urandom);
      bus.flush = ($urandom_range(24, 0) == 0);
      cycle();
    end
    bus.cs = 1'b0;
    bus.flush = 1'b0;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
